zbuf_depth_test: RTL and testbench
==================================

Name: zbuf_depth_test

Overview:
Depth-test stage of the Z-buffer pipeline. It accepts pixel fragments (address, depth, colour) over a valid/ready handshake and does a read-compare-write against the depth memory. On a pass it writes the new depth and emits a frame-buffer pixel write. It also runs the depth-memory clear sequence, using an internal up-counter that sweeps every address.

Parameters:
ADDR_BITS, 8, width of pixel address; depth memory holds 2**ADDR_BITS entries
Z_BITS, 8, depth value width; all-ones is the farthest depth and the clear value
COLOR_BITS, 8, pixel colour width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
clear_start  in  1  request full depth-memory clear; sampled only in IDLE
busy  out  1  high whenever state != IDLE
clear_done  out  1  one-cycle pulse after the last clear write
frag_valid  in  1  fragment present
frag_ready  out  1  fragment accepted when valid&ready on a rising edge
frag_addr  in  ADDR_BITS  fragment pixel address
frag_z  in  Z_BITS  fragment depth, smaller = closer
frag_color  in  COLOR_BITS  fragment colour
zmem_addr  out  ADDR_BITS  depth memory address
zmem_rd_en  out  1  depth read strobe; data valid on zmem_rdata one cycle later
zmem_rdata  in  Z_BITS  depth read data
zmem_we  out  1  depth write strobe
zmem_wdata  out  Z_BITS  depth write data
fb_we  out  1  frame-buffer write strobe
fb_addr  out  ADDR_BITS  frame-buffer address
fb_data  out  COLOR_BITS  frame-buffer colour

Behaviour:
- States: IDLE, CLEAR, READ, COMPARE. Reset forces IDLE and clears the clear counter, latches and clear_done.
- While reset is high, all outputs are 0, including frag_ready. Depth memory contents after reset are undefined; software must issue a clear.
- IDLE transitions:
  - clear_start=1: go to CLEAR and zero the counter. clear_start has priority; frag_ready=0 in any cycle where clear_start=1.
  - frag_valid & frag_ready: latch addr/z/color and go to READ.
  - frag_ready = (state==IDLE) & !clear_start, combinational.
- CLEAR:
  - Each cycle: zmem_we=1, zmem_addr=counter, zmem_wdata=all ones, then counter+1.
  - When the counter equals 2**ADDR_BITS-1, go to IDLE; clear_done pulses 1 in the following cycle (first IDLE cycle).
  - A clear takes exactly 2**ADDR_BITS cycles. The counter wraps to 0 and never stops early.
  - clear_start is ignored outside IDLE.
- READ: zmem_rd_en=1, zmem_addr=latched addr; go to COMPARE.
- COMPARE: pass = (latched_z < zmem_rdata), unsigned Z_BITS compare.
  - If pass, in this same cycle: zmem_we=1, zmem_addr=latched addr, zmem_wdata=latched_z; fb_we=1, fb_addr=latched addr, fb_data=latched colour.
  - Always go to IDLE.
- Throughput: one fragment per 3 cycles (accept, READ, COMPARE). frag_ready returns high in the cycle after COMPARE.
- All strobes (zmem_rd_en, zmem_we, fb_we) are 0 in every state/cycle not listed above. zmem_rd_en and zmem_we are never both high.
- Address/data outputs are don't-care when their strobe is low, but are driven to 0 in IDLE.
- Reset mid-CLEAR or mid-fragment aborts the operation immediately: no further writes and no clear_done.

Optional Feature:
ZBUF_LEQUAL_EN:
- Defined: pass = (latched_z <= zmem_rdata). Equal depth overwrites, so a fragment at the clear value (all ones) passes.
- Undefined: strict less-than as above; equal depth is rejected.

Test Plan:
- Clear: reset, then pulse clear_start in IDLE.
  - Expect exactly 256 consecutive zmem_we cycles, addr 0..255, wdata 0xFF.
  - busy is high for those 256 cycles; clear_done pulses once in the next cycle.
  - No frag_ready during the clear.
- Pass: after clear, fragment addr=5, z=100, color=0x3C.
  - Expect zmem_rd_en addr 5 in READ.
  - In COMPARE: zmem_we addr 5 wdata 100, and fb_we addr 5 data 0x3C.
- Fail:
  - Next fragment addr=5, z=150: no zmem_we, no fb_we.
  - Fragment addr=5, z=100: no writes without ZBUF_LEQUAL_EN; writes 100/colour with it.
- Streaming: frag_valid held high with 4 fragments to distinct addresses.
  - Expect accepts exactly every 3rd cycle and 4 fb_we pulses with matching addr/colour.
- Priority/abort:
  - clear_start and frag_valid high together in IDLE: CLEAR wins, fragment is not accepted until the clear finishes.
  - Assert reset at clear counter=100: zmem_we drops at once, no clear_done, state returns to IDLE.

Source files
------------

// File: rtl/zbuf_depth_test.sv
// Depth-test stage: read-compare-write of one fragment against depth memory, plus full-memory clear.
// Latency: fragment accept -> READ (1 cycle) -> COMPARE with writes (1 cycle); clear takes 2**ADDR_BITS cycles.
// Backpressure: frag_ready is high only in IDLE with no clear request, giving one fragment per 3 cycles.
//
// Ports: clk/reset (async active-high); clear_start/busy/clear_done (clear control);
//        frag_* (fragment valid/ready input); zmem_* (depth memory, 1-cycle read latency);
//        fb_* (frame-buffer pixel write).
// Optional: define ZBUF_LEQUAL_EN to make equal depth pass (<=) instead of strict less-than.
module zbuf_depth_test #(
    parameter int ADDR_BITS  = 8,
    parameter int Z_BITS     = 8,
    parameter int COLOR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  clear_done,
    input  logic                  frag_valid,
    output logic                  frag_ready,
    input  logic [ADDR_BITS-1:0]  frag_addr,
    input  logic [Z_BITS-1:0]     frag_z,
    input  logic [COLOR_BITS-1:0] frag_color,
    output logic [ADDR_BITS-1:0]  zmem_addr,
    output logic                  zmem_rd_en,
    input  logic [Z_BITS-1:0]     zmem_rdata,
    output logic                  zmem_we,
    output logic [Z_BITS-1:0]     zmem_wdata,
    output logic                  fb_we,
    output logic [ADDR_BITS-1:0]  fb_addr,
    output logic [COLOR_BITS-1:0] fb_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        READ    = 2'd2,
        COMPARE = 2'd3
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
    localparam logic [Z_BITS-1:0]    FAR_Z     = '1;

    state_t                  state;
    logic [ADDR_BITS-1:0]    clr_cnt;
    logic [ADDR_BITS-1:0]    lat_addr;
    logic [Z_BITS-1:0]       lat_z;
    logic [COLOR_BITS-1:0]   lat_color;
    logic                    pass;

`ifdef ZBUF_LEQUAL_EN
    assign pass = (lat_z <= zmem_rdata);
`else
    assign pass = (lat_z < zmem_rdata);
`endif

    // Reset gating keeps ready low while reset is held even though state already reads IDLE.
    assign frag_ready = (state == IDLE) && !clear_start && !reset;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            lat_addr   <= '0;
            lat_z      <= '0;
            lat_color  <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Clear request outranks a pending fragment.
                    if (clear_start) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else if (frag_valid) begin
                        lat_addr  <= frag_addr;
                        lat_z     <= frag_z;
                        lat_color <= frag_color;
                        state     <= READ;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= IDLE;
                        clear_done <= 1'b1;
                    end
                end
                READ:    state <= COMPARE;
                COMPARE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        zmem_addr  = '0;
        zmem_rd_en = 1'b0;
        zmem_we    = 1'b0;
        zmem_wdata = '0;
        fb_we      = 1'b0;
        fb_addr    = '0;
        fb_data    = '0;
        unique case (state)
            CLEAR: begin
                zmem_we    = 1'b1;
                zmem_addr  = clr_cnt;
                zmem_wdata = FAR_Z;
            end
            READ: begin
                zmem_rd_en = 1'b1;
                zmem_addr  = lat_addr;
            end
            COMPARE: begin
                zmem_addr = lat_addr;
                if (pass) begin
                    zmem_we    = 1'b1;
                    zmem_wdata = lat_z;
                    fb_we      = 1'b1;
                    fb_addr    = lat_addr;
                    fb_data    = lat_color;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_zbuf_depth_test.sv
module tb_zbuf_depth_test;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_start = 1'b0;
    logic       frag_valid = 1'b0;
    logic [7:0] frag_addr = '0;
    logic [7:0] frag_z = '0;
    logic [7:0] frag_color = '0;
    logic       busy, clear_done, frag_ready;
    logic [7:0] zmem_addr, zmem_wdata, fb_addr, fb_data;
    logic       zmem_rd_en, zmem_we, fb_we;
    logic [7:0] zmem_rdata = '0;

    zbuf_depth_test #(.ADDR_BITS(8), .Z_BITS(8), .COLOR_BITS(8)) dut (
        .clk(clk), .reset(reset), .clear_start(clear_start), .busy(busy),
        .clear_done(clear_done), .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_addr(frag_addr), .frag_z(frag_z), .frag_color(frag_color),
        .zmem_addr(zmem_addr), .zmem_rd_en(zmem_rd_en), .zmem_rdata(zmem_rdata),
        .zmem_we(zmem_we), .zmem_wdata(zmem_wdata), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_data(fb_data)
    );

    always #5 clk = ~clk;

    // Depth memory environment: write on strobe, read data one cycle after rd_en.
    logic [7:0] zmem [DEPTH];
    always @(posedge clk) begin
        if (zmem_we)    zmem[zmem_addr] <= zmem_wdata;
        if (zmem_rd_en) zmem_rdata <= zmem[zmem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: expected per-cycle output events keyed by cycle number.
    typedef struct packed {
        bit rd, we, fb, done;
        logic [7:0] zaddr, wdata, faddr, fdata;
    } exp_t;

    exp_t       exp_q [int];
    int         busy_end = -1;
    logic [7:0] ref_z [DEPTH];
    int         n_acc = 0, acc_cyc = 0;
    int         n_zwe = 0, n_done = 0, n_fb = 0;
    logic [7:0] last_fb_addr = '0, last_fb_data = '0;

    always @(negedge clk) begin
        exp_t e;
        bit   idle, eready;
        e = '0;
        if (exp_q.exists(cyc)) begin
            e = exp_q[cyc];
            exp_q.delete(cyc);
        end
        if (reset) begin
            e = '0;
            exp_q.delete();
            busy_end = cyc;
        end
        idle   = reset ? 1'b1 : (cyc > busy_end);
        eready = !reset && idle && !clear_start;

        chk("busy", busy, !idle);
        chk("frag_ready", frag_ready, eready);
        chk("zmem_rd_en", zmem_rd_en, e.rd);
        chk("zmem_we", zmem_we, e.we);
        chk("fb_we", fb_we, e.fb);
        chk("clear_done", clear_done, e.done);
        if (idle) begin
            chk("idle_zmem_addr", zmem_addr, 0);
            chk("idle_zmem_wdata", zmem_wdata, 0);
            chk("idle_fb_addr", fb_addr, 0);
            chk("idle_fb_data", fb_data, 0);
        end else begin
            if (e.rd || e.we) chk("zmem_addr", zmem_addr, e.zaddr);
            if (e.we)         chk("zmem_wdata", zmem_wdata, e.wdata);
            if (e.fb) begin
                chk("fb_addr", fb_addr, e.faddr);
                chk("fb_data", fb_data, e.fdata);
            end
        end

        if (zmem_we)    n_zwe++;
        if (clear_done) n_done++;
        if (fb_we) begin
            n_fb++;
            last_fb_addr = fb_addr;
            last_fb_data = fb_data;
        end

        // Advance the model on inputs that the coming rising edge will sample.
        if (!reset && idle) begin
            if (clear_start) begin
                for (int i = 0; i < DEPTH; i++) begin
                    exp_t w;
                    w = '0;
                    w.we = 1; w.zaddr = 8'(i); w.wdata = 8'hFF;
                    exp_q[cyc + 1 + i] = w;
                    ref_z[i] = 8'hFF;
                end
                begin
                    exp_t d;
                    d = '0;
                    d.done = 1;
                    exp_q[cyc + DEPTH + 1] = d;
                end
                busy_end = cyc + DEPTH;
            end else if (frag_valid) begin
                exp_t r, c;
                bit   pass;
                r = '0; c = '0;
                r.rd = 1; r.zaddr = frag_addr;
                exp_q[cyc + 1] = r;
`ifdef ZBUF_LEQUAL_EN
                pass = (frag_z <= ref_z[frag_addr]);
`else
                pass = (frag_z < ref_z[frag_addr]);
`endif
                if (pass) begin
                    c.we = 1; c.zaddr = frag_addr; c.wdata = frag_z;
                    c.fb = 1; c.faddr = frag_addr; c.fdata = frag_color;
                    ref_z[frag_addr] = frag_z;
                end
                exp_q[cyc + 2] = c;
                busy_end = cyc + 2;
                n_acc++;
                acc_cyc = cyc;
            end
        end
    end

    // Waits (bounded) until the model registers an acceptance; valid stays as the caller left it.
    task automatic wait_accept(input string name);
        int prev;
        bit got;
        prev = n_acc;
        got  = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge clk);
            if (n_acc != prev) got = 1;
        end
        #1;
        if (!got) chk({name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic send_frag(input logic [7:0] a, input logic [7:0] z, input logic [7:0] col);
        frag_addr = a; frag_z = z; frag_color = col; frag_valid = 1'b1;
        wait_accept("frag");
        frag_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear(output int c0);
        clear_start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        clear_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, fb0, zwe0, done0, prev_acc;
        int acc [4];

        // Reset held with inputs active: outputs must stay low.
        frag_valid = 1'b1; clear_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        frag_valid = 1'b0; clear_start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full clear.
        pulse_clear(c0);
        repeat (260) @(posedge clk);
        #1;
        chk("clear_write_count", n_zwe, 256);
        chk("clear_done_count", n_done, 1);
        chk("mem_after_clear_0", zmem[0], 8'hFF);
        chk("mem_after_clear_255", zmem[255], 8'hFF);

        // Pass, fail, equal.
        send_frag(8'd5, 8'd100, 8'h3C);
        chk("pass_fb_count", n_fb, 1);
        chk("pass_fb_addr", last_fb_addr, 8'd5);
        chk("pass_fb_data", last_fb_data, 8'h3C);
        chk("pass_mem", zmem[5], 8'd100);
        send_frag(8'd5, 8'd150, 8'h99);
        chk("farther_fb_count", n_fb, 1);
        send_frag(8'd5, 8'd100, 8'h77);
`ifdef ZBUF_LEQUAL_EN
        chk("equal_fb_count", n_fb, 2);
        chk("equal_fb_data", last_fb_data, 8'h77);
`else
        chk("equal_fb_count", n_fb, 1);
`endif
        chk("equal_mem", zmem[5], 8'd100);

        // Streaming: valid held, four fragments to distinct addresses.
        fb0 = n_fb;
        frag_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            frag_addr = 8'(10 + k); frag_z = 8'(1 + k); frag_color = 8'(8'hA0 + k);
            wait_accept("stream");
            acc[k] = acc_cyc;
        end
        frag_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 1; k < 4; k++) chk("stream_spacing", acc[k] - acc[k-1], 3);
        chk("stream_fb_count", n_fb - fb0, 4);
        chk("stream_last_addr", last_fb_addr, 8'd13);
        chk("stream_last_data", last_fb_data, 8'hA3);

        // Clear and fragment together: clear wins, fragment waits for the clear to finish.
        frag_addr = 8'd20; frag_z = 8'd50; frag_color = 8'h55; frag_valid = 1'b1;
        prev_acc = n_acc;
        pulse_clear(c0);
        chk("priority_no_accept", n_acc - prev_acc, 0);
        wait_accept("priority");
        frag_valid = 1'b0;
        chk("priority_accept_delay", acc_cyc - c0, 257);
        repeat (3) @(posedge clk);
        #1;
        chk("priority_fb_addr", last_fb_addr, 8'd20);
        chk("priority_stale_cleared", zmem[10], 8'hFF);

        // Reset at clear counter 100 aborts immediately.
        zwe0 = n_zwe; done0 = n_done;
        pulse_clear(c0);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_we_drop", zmem_we, 0);
        chk("abort_busy_drop", busy, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("abort_write_count", n_zwe - zwe0, 100);
        chk("abort_no_done", n_done - done0, 0);

        // Recovery: clear again then a passing fragment.
        pulse_clear(c0);
        repeat (260) @(posedge clk);
        #1;
        fb0 = n_fb;
        send_frag(8'd100, 8'hFE, 8'h11);
        chk("recover_fb_count", n_fb - fb0, 1);
        chk("recover_fb_data", last_fb_data, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
